// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
// Optional majority-vote evaluation is enabled with `define PUF_VOTE_EN.
package puf_pkg;

   localparam int unsigned C_LENGTH_DEF = 8;
   localparam int unsigned SYNC_STAGES  = 2;

   // Feedback taps c[7]^c[5]^c[4]^c[3]
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StLaunch,
      StSample,
      StDone
   } state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Challenge LFSR: loads a seed (zero replaced by 1) and shifts left with tap feedback.
module puf_lfsr
   import puf_pkg::*;
#(
   parameter int unsigned          C_LENGTH = C_LENGTH_DEF,
   parameter logic [C_LENGTH-1:0]  TAPS     = C_LENGTH'(LFSR_TAPS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                adv,
   input  logic [C_LENGTH-1:0] seed,
   output logic [C_LENGTH-1:0] value
);

   logic [C_LENGTH-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         // An all-zero state would lock the LFSR
         value_d = (seed == '0) ? C_LENGTH'(1) : seed;
      end else if (adv) begin
         value_d = {value_q[C_LENGTH-2:0], ^(value_q & TAPS)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) value_q <= '0;
      else        value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/puf_challenger.sv
// Arbiter PUF challenge sequencer and response collector with valid/ack host handshake.
// Define PUF_VOTE_EN to evaluate each challenge three times and shift the majority bit.
module puf_challenger
   import puf_pkg::*;
#(
   parameter int unsigned C_LENGTH    = C_LENGTH_DEF,
   parameter int unsigned RESP_BITS   = 16,
   parameter int unsigned SETTLE_CYC  = 2,
   parameter int unsigned CAPTURE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [C_LENGTH-1:0]  seed,
   output logic                 busy,
   output logic [C_LENGTH-1:0]  challenge,
   output logic                 pulse,
   input  logic                 response_in,
   output logic [RESP_BITS-1:0] resp_word,
   output logic                 resp_valid,
   input  logic                 resp_ack
);

   localparam int unsigned MAX_CYC = (SETTLE_CYC > CAPTURE_CYC) ?
                                     ((SETTLE_CYC > SYNC_STAGES) ? SETTLE_CYC : SYNC_STAGES) :
                                     ((CAPTURE_CYC > SYNC_STAGES) ? CAPTURE_CYC : SYNC_STAGES);
   localparam int unsigned CYC_W   = $clog2(MAX_CYC) + 1;
   localparam int unsigned CNT_W   = $clog2(RESP_BITS + 1);

   state_e               state_q, state_d;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RESP_BITS-1:0] word_q, word_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 sync_bit;
   logic                 lfsr_load, lfsr_adv;
   logic                 shift_en, new_bit;

`ifdef PUF_VOTE_EN
   logic [1:0] run_q, run_d;
   logic [1:0] votes_q, votes_d;
`endif

   puf_lfsr #(
      .C_LENGTH (C_LENGTH)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .adv   (lfsr_adv),
      .seed  (seed),
      .value (challenge)
   );

   // response_in is asynchronous to clk
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], response_in};
   end
   assign sync_bit = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      shift_en  = 1'b0;
      new_bit   = sync_bit;
`ifdef PUF_VOTE_EN
      run_d     = run_q;
      votes_d   = votes_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               lfsr_load = 1'b1;
               word_d    = '0;
               cnt_d     = '0;
               cyc_d     = '0;
`ifdef PUF_VOTE_EN
               run_d     = '0;
`endif
               state_d   = StSetup;
            end
         end
         StSetup: begin
            if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
               cyc_d   = '0;
               state_d = StLaunch;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         StLaunch: begin
            if (cyc_q == CYC_W'(CAPTURE_CYC - 1)) begin
               cyc_d   = '0;
               state_d = StSample;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         StSample: begin
            if (cyc_q == CYC_W'(SYNC_STAGES - 1)) begin
               cyc_d = '0;
`ifdef PUF_VOTE_EN
               if (run_q != 2'd2) begin
                  // Relaunch the same challenge without advancing the LFSR
                  votes_d = {votes_q[0], sync_bit};
                  run_d   = run_q + 2'd1;
                  state_d = StSetup;
               end else begin
                  new_bit  = maj3(votes_q[1], votes_q[0], sync_bit);
                  run_d    = '0;
                  shift_en = 1'b1;
               end
`else
               shift_en = 1'b1;
`endif
               if (shift_en) begin
                  word_d   = {word_q[RESP_BITS-2:0], new_bit};
                  lfsr_adv = 1'b1;
                  cnt_d    = cnt_q + 1'b1;
                  state_d  = (cnt_q == CNT_W'(RESP_BITS - 1)) ? StDone : StSetup;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         StDone: begin
            if (resp_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cyc_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

`ifdef PUF_VOTE_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q   <= '0;
         votes_q <= '0;
      end else begin
         run_q   <= run_d;
         votes_q <= votes_d;
      end
   end
`endif

   assign busy       = (state_q != StIdle);
   assign pulse      = (state_q == StLaunch) || (state_q == StSample);
   assign resp_valid = (state_q == StDone);
   assign resp_word  = word_q;

endmodule
